// File: rtl/pipe_pkg.sv
// Shared constants for pipeline segment registers: occupancy encoding,
// per-stage record widths and halt-flag positions used by the stage wrappers.
package pipe_pkg;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_FULL  = 2'd1;
   localparam logic [1:0] OCC_SKID  = 2'd2;

   localparam int unsigned IF_ID_W = 72;
   localparam int unsigned ID_EX_W = 104;
   localparam int unsigned EX_M_W  = 80;
   localparam int unsigned M_WB_W  = 72;

   localparam int unsigned IF_ID_HALT = IF_ID_W - 1;
   localparam int unsigned ID_EX_HALT = ID_EX_W - 1;
   localparam int unsigned EX_M_HALT  = EX_M_W - 1;
   localparam int unsigned M_WB_HALT  = M_WB_W - 1;

   // State encoding equals the number of held entries.
   typedef enum logic [1:0] {
      SEG_EMPTY = OCC_EMPTY,
      SEG_FULL  = OCC_FULL,
      SEG_SKID  = OCC_SKID
   } seg_state_t;

endpackage

// File: rtl/pipe_seg_reg.sv
// Pipeline segment register: valid/ready handshake on an opaque stage record,
// optional skid entry, synchronous flush, debug clock enable, sticky halt.
module pipe_seg_reg
   import pipe_pkg::*;
#(
   parameter int unsigned       DATA_W    = 104,
   parameter bit                SKID_EN   = 1'b1,
   parameter int unsigned       HALT_BIT  = DATA_W - 1,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_clk_en,
   input  logic              i_flush,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic [1:0]        o_occupancy,
   output logic              o_halted
);

   seg_state_t        state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic              valid_q;
   logic              halted_q, halted_d;
   logic              accept, deliver;

   assign accept   = i_clk_en & i_valid & o_ready & ~i_flush;
   assign deliver  = i_clk_en & valid_q & i_ready & ~i_flush;
   assign halted_d = halted_q | (deliver & main_q[HALT_BIT]);

   if (SKID_EN) begin : g_skid
      logic [DATA_W-1:0] skid_q, skid_d;

      // No combinational path from i_ready: space depends only on occupancy.
      assign o_ready = i_clk_en & ~halted_q & (state_q != SEG_SKID);

      always_comb begin
         state_d = state_q;
         main_d  = main_q;
         skid_d  = skid_q;
         if (i_clk_en && i_flush) begin
            state_d = SEG_EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
         end else begin
            unique case (state_q)
               SEG_EMPTY: begin
                  if (accept) begin
                     state_d = SEG_FULL;
                     main_d  = i_data;
                  end
               end
               SEG_FULL: begin
                  if (accept && deliver) begin
                     main_d = i_data;
                  end else if (accept) begin
                     state_d = SEG_SKID;
                     skid_d  = i_data;
                  end else if (deliver) begin
                     state_d = SEG_EMPTY;
                  end
               end
               SEG_SKID: begin
                  if (deliver) begin
                     state_d = SEG_FULL;
                     main_d  = skid_q;
                  end
               end
               default: state_d = SEG_EMPTY;
            endcase
         end
      end

      always_ff @(posedge i_clk or posedge i_reset) begin
         if (i_reset) skid_q <= RESET_VAL;
         else         skid_q <= skid_d;
      end
   end else begin : g_single
      assign o_ready = i_clk_en & ~halted_q & (~valid_q | i_ready);

      always_comb begin
         state_d = state_q;
         main_d  = main_q;
         if (i_clk_en && i_flush) begin
            state_d = SEG_EMPTY;
            main_d  = RESET_VAL;
         end else begin
            unique case (state_q)
               SEG_EMPTY: begin
                  if (accept) begin
                     state_d = SEG_FULL;
                     main_d  = i_data;
                  end
               end
               SEG_FULL: begin
                  if (accept) begin
                     main_d = i_data;
                  end else if (deliver) begin
                     state_d = SEG_EMPTY;
                  end
               end
               default: state_d = SEG_EMPTY;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= SEG_EMPTY;
         main_q   <= RESET_VAL;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         main_q   <= main_d;
         valid_q  <= (state_d != SEG_EMPTY);
         halted_q <= halted_d;
      end
   end

   assign o_valid     = valid_q;
   assign o_data      = main_q;
   assign o_occupancy = 2'(state_q);
   assign o_halted    = halted_q;

endmodule

// File: doc/pipe_seg_reg.md
Name: pipe_seg_reg

Overview:
Parametrised pipeline segment register, the successor to the fixed per-stage registers (IF/ID … MEM/WB).
- Carries an opaque DATA_W-bit stage record with a valid/ready handshake.
- Optional 2-entry skid buffer for back-pressure.
- Synchronous flush, debug-unit clock enable, and sticky halt detection.
- Instantiated between any two pipeline stages; the record is packed and unpacked by the stage wrappers.

Parameters:
DATA_W, 104, width of the stage record.
SKID_EN, 1, 1 = main + skid entry (full throughput under back-pressure); 0 = single register.
HALT_BIT, DATA_W-1, index of the halt flag inside the record.
RESET_VAL, {DATA_W{1'b0}}, value loaded into the data registers on reset and flush.

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_clk_en  in  1  debug-unit step enable; when 0, all state is frozen
i_flush  in  1  synchronous flush (bubble insert)
i_valid  in  1  upstream record valid
o_ready  out  1  block can accept a record this cycle
i_data  in  DATA_W  upstream record
o_valid  out  1  downstream record valid
i_ready  in  1  downstream accepts
o_data  out  DATA_W  downstream record (always driven from the main register)
o_occupancy  out  2  entries held (0..2; max 1 when SKID_EN=0)
o_halted  out  1  sticky: a record with HALT_BIT=1 has been delivered

Behaviour:
- Reset (async, i_reset=1): o_valid=0, o_data=RESET_VAL, skid empty, o_occupancy=0, o_halted=0. Reset mid-transfer discards all held records.
- Accept event: i_clk_en & i_valid & o_ready & !i_flush at posedge.
- Deliver event: i_clk_en & o_valid & i_ready & !i_flush at posedge.
- Latency: a record accepted at edge N appears on o_data/o_valid after edge N when the block is empty; throughput is 1 record/cycle.
- o_ready (combinational):
  - SKID_EN=1: i_clk_en & !o_halted & (o_occupancy<2). Independent of i_ready, so there is no ready combinational path.
  - SKID_EN=0: i_clk_en & !o_halted & (!o_valid | i_ready).
- States, SKID_EN=1:
  - EMPTY (occ 0): accept -> FULL, main<=i_data.
  - FULL (occ 1):
    - accept & deliver -> FULL, main<=i_data.
    - accept only -> SKID, skid<=i_data.
    - deliver only -> EMPTY.
  - SKID (occ 2): deliver -> FULL, main<=skid. No accept is possible (o_ready=0).
- SKID_EN=0: states EMPTY/FULL only; the skid register is not synthesised.
- Record order is strictly FIFO; a record is never duplicated or dropped except by flush or reset.
- i_clk_en=0: no state change, including flush and halt. Outputs hold their values; o_ready=0.
- Flush (i_flush & i_clk_en):
  - next state EMPTY; o_valid=0; main and skid <= RESET_VAL.
  - A simultaneous accept or deliver is suppressed; flush wins.
  - o_halted is unaffected.
- Halt:
  - o_halted<=1 on a deliver event where o_data[HALT_BIT]=1.
  - Once set, o_ready=0 permanently; the downstream may still drain the remaining entries.
  - Cleared only by reset.
- Data registers may change when o_valid=0; downstream must qualify o_data with o_valid.

Decomposition:
- Shared package pipe_pkg holds:
  - occupancy encoding constants (OCC_EMPTY=0, OCC_FULL=1, OCC_SKID=2);
  - per-stage record widths (IF_ID_W, ID_EX_W, EX_M_W, M_WB_W);
  - halt-bit position constants used by the wrappers.
- No sub-module; a single module with a generate branch on SKID_EN.

Test Plan:
- Reset then stream 0xA1, 0xA2, 0xA3 with i_ready=1 -> each appears one cycle after acceptance; o_occupancy stays at 1; no gaps.
- SKID_EN=1: accept 0x11; drop i_ready; accept 0x22 -> o_occupancy=2, o_ready=0. Raise i_ready -> deliver 0x11 then 0x22 in order.
- i_clk_en=0 for 3 cycles with i_valid=1 and i_ready=1 while holding 0x55 -> o_data=0x55, o_occupancy and o_valid unchanged, no accept.
- In SKID state, assert i_flush together with i_valid -> next cycle o_valid=0, o_occupancy=0, o_data=RESET_VAL, the incoming record is discarded.
- Deliver a record with bit HALT_BIT=1 -> o_halted=1 the next cycle, o_ready=0 thereafter; a subsequent flush leaves o_halted=1; only i_reset clears it.
- Assert i_reset asynchronously mid-cycle in SKID state -> outputs reach reset values immediately, without waiting for a clock edge.
